// File: rtl/gbf_stream_loader.sv
// gbf_stream_loader: header + payload stream steered into one of
// NUM_CH global-buffer write ports at incrementing addresses.
module gbf_stream_loader #(
    parameter int NUM_CH     = 5,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  IN_Val,
    output logic                  IN_Rdy,
    input  logic [DATA_WIDTH-1:0] IN_Dat,
    input  logic [NUM_CH-1:0]     GBF_Val,
    output logic [NUM_CH-1:0]     GBF_EnWr,
    output logic [ADDR_WIDTH-1:0] GBF_AddrWr,
    output logic [DATA_WIDTH-1:0] GBF_DatWr,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Err
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        DONE
    } state_t;

    state_t state;
    state_t stateNext;

    logic [7:0]            chReg;
    logic [ADDR_WIDTH-1:0] addrReg;
    logic [LEN_WIDTH-1:0]  remReg;

    logic [7:0]            hdrCh;
    logic [ADDR_WIDTH-1:0] hdrBase;
    logic [LEN_WIDTH-1:0]  hdrLen;
    logic                  hdrLegal;
    logic [NUM_CH-1:0]     chHot;
    logic                  chOk;
    logic                  accept;
    logic                  lastWord;

    assign hdrCh    = IN_Dat[7:0];
    assign hdrBase  = IN_Dat[8 +: ADDR_WIDTH];
    assign hdrLen   = IN_Dat[32 +: LEN_WIDTH];
    assign hdrLegal = ({24'd0, hdrCh} < 32'(NUM_CH));

    // Shifting past NUM_CH yields zero, so an illegal id never selects a port.
    assign chHot    = NUM_CH'(1) << chReg;
    assign chOk     = |(GBF_Val & chHot);
    assign accept   = IN_Val && IN_Rdy;
    assign lastWord = (remReg == LEN_WIDTH'(1));

    assign Busy = (state != IDLE);
    assign Done = (state == DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and stream-ready decode.
    always_comb begin
        stateNext = state;
        IN_Rdy    = 1'b0;
        unique case (state)
            IDLE: begin
                IN_Rdy = 1'b1;
                if (IN_Val) begin
                    if (!hdrLegal) begin
                        // An empty discarded transfer has nothing to drain.
                        stateNext = (hdrLen == '0) ? IDLE : DRAIN;
                    end else if (hdrLen == '0) begin
                        stateNext = DONE;
                    end else begin
                        stateNext = LOAD;
                    end
                end
            end
            LOAD: begin
                IN_Rdy = chOk;
                if (IN_Val && chOk && lastWord) begin
                    stateNext = DONE;
                end
            end
            DRAIN: begin
                IN_Rdy = 1'b1;
                if (IN_Val && lastWord) begin
                    stateNext = IDLE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Transfer context: channel, running address and remaining count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chReg   <= '0;
            addrReg <= '0;
            remReg  <= '0;
        end else if (accept) begin
            if (state == IDLE) begin
                chReg   <= hdrCh;
                addrReg <= hdrBase;
                remReg  <= hdrLen;
            end else begin
                remReg <= remReg - LEN_WIDTH'(1);
                if (state == LOAD) begin
                    addrReg <= addrReg + ADDR_WIDTH'(1);
                end
            end
        end
    end

    // Registered write port and error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            GBF_EnWr   <= '0;
            GBF_AddrWr <= '0;
            GBF_DatWr  <= '0;
            Err        <= 1'b0;
        end else begin
            Err <= accept && (state == IDLE) && !hdrLegal;
            if (accept && (state == LOAD)) begin
                GBF_EnWr   <= chHot;
                GBF_AddrWr <= addrReg;
                GBF_DatWr  <= IN_Dat;
            end else begin
                GBF_EnWr <= '0;
            end
        end
    end

endmodule

// File: tb/tb_gbf_stream_loader.sv
// tb_gbf_stream_loader: directed + random transfers, scoreboarded
// against a transfer-level model of the loader.
module tb_gbf_stream_loader;

    localparam int NCH = 5;
    localparam int DW  = 64;
    localparam int AW  = 12;
    localparam int LW  = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          inVal = 1'b0;
    logic          inRdy;
    logic [DW-1:0] inDat = '0;
    logic [NCH-1:0] dirVal = '1;
    logic [NCH-1:0] gbfRand = '1;
    logic [NCH-1:0] gbfVal;
    logic          randMode = 1'b0;
    logic [NCH-1:0] enWr;
    logic [AW-1:0] addrWr;
    logic [DW-1:0] datWr;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    assign gbfVal = randMode ? gbfRand : dirVal;

    always @(posedge clk) gbfRand <= NCH'($urandom | $urandom);

    gbf_stream_loader #(
        .NUM_CH(NCH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .IN_Val(inVal), .IN_Rdy(inRdy), .IN_Dat(inDat),
        .GBF_Val(gbfVal), .GBF_EnWr(enWr), .GBF_AddrWr(addrWr),
        .GBF_DatWr(datWr), .Busy(busy), .Done(done), .Err(err)
    );

    int nChecks = 0;
    int nPass = 0;

    task automatic check(input string nm, input logic [63:0] got,
                         input logic [63:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s got=%h exp=%h", nm, got, exp);
    endtask

    typedef struct {
        logic [NCH-1:0] en;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  dat;
    } wr_t;

    wr_t wq[$];
    bit  doneQ[$];
    int  errQ[$];

    // Reference model of the transfer in flight.
    int mCh, mBase, mLen, mIdx;
    bit mLegal = 0;

    // Monitor: every write/Done/Err the DUT shows must match the model.
    wr_t e;
    bit  hw;
    bit  prevDone = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prevDone = 0;
        end else begin
            if (prevDone) check("busy_after_done", 64'(busy), 64'(0));
            if (enWr != '0) begin
                check("write_expected", 64'(wq.size() != 0), 64'(1));
                if (wq.size() != 0) begin
                    e = wq.pop_front();
                    check("wr_en", 64'(enWr), 64'(e.en));
                    check("wr_addr", 64'(addrWr), 64'(e.addr));
                    check("wr_dat", datWr, e.dat);
                end
            end
            if (done) begin
                check("done_expected", 64'(doneQ.size() != 0), 64'(1));
                if (doneQ.size() != 0) begin
                    hw = doneQ.pop_front();
                    check("done_with_last_wr", 64'(enWr != '0), 64'(hw));
                end
            end
            if (err) begin
                check("err_expected", 64'(errQ.size() != 0), 64'(1));
                if (errQ.size() != 0) void'(errQ.pop_front());
            end
            prevDone = done;
        end
    end

    task automatic sendWord(input logic [DW-1:0] d, output int waited);
        inVal = 1'b1;
        inDat = d;
        waited = 0;
        @(negedge clk);
        while (!inRdy && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 200) check("accept_timeout", 64'(waited), 64'(0));
        @(posedge clk);
        #1;
        inVal = 1'b0;
    endtask

    task automatic sendHeader(input int ch, input int base, input int len,
                              output int waited);
        logic [DW-1:0] h;
        h = '0;
        h[7:0] = ch[7:0];
        h[8 +: AW] = base[AW-1:0];
        h[32 +: LW] = len[LW-1:0];
        sendWord(h, waited);
        mCh = ch;
        mBase = base;
        mLen = len;
        mIdx = 0;
        mLegal = (ch < NCH);
        if (!mLegal) errQ.push_back(ch);
        if (mLegal && len == 0) doneQ.push_back(1'b0);
    endtask

    task automatic sendPayload(input logic [DW-1:0] d, output int waited);
        wr_t w;
        sendWord(d, waited);
        if (mLegal) begin
            w.en = NCH'(1) << mCh;
            w.addr = AW'((mBase + mIdx) % (1 << AW));
            w.dat = d;
            wq.push_back(w);
        end
        mIdx++;
        if (mLegal && mIdx == mLen) doneQ.push_back(1'b1);
    endtask

    task automatic gap();
        int n;
        n = $urandom_range(0, 2);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_rdy"}, 64'(inRdy), 64'(1));
        check({tag, "_en"}, 64'(enWr), 64'(0));
        check({tag, "_addr"}, 64'(addrWr), 64'(0));
        check({tag, "_dat"}, datWr, 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_err"}, 64'(err), 64'(0));
    endtask

    initial begin
        int w;
        logic [DW-1:0] d;
        #12;
        checkResetOutputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic 4-word transfer to ch2.
        sendHeader(2, 'h010, 4, w);
        for (int i = 0; i < 4; i++) sendPayload(64'hD0 + 64'(i), w);
        repeat (3) @(posedge clk);
        #1;

        // Same transfer with ch2 stalled for 3 cycles after word 2.
        sendHeader(2, 'h010, 4, w);
        sendPayload(64'hA0, w);
        sendPayload(64'hA1, w);
        dirVal = 5'b11011;
        inVal = 1'b1;
        inDat = 64'hA2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_rdy", 64'(inRdy), 64'(0));
            if (i > 0) check("stall_en", 64'(enWr), 64'(0));
        end
        @(posedge clk);
        #1;
        dirVal = '1;
        sendPayload(64'hA2, w);
        sendPayload(64'hA3, w);
        repeat (3) @(posedge clk);
        #1;

        // Illegal channel: Err pulse, payload drained regardless of Val.
        dirVal = '0;
        sendHeader(7, 'h055, 3, w);
        @(negedge clk);
        check("err_timing", 64'(err), 64'(1));
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            sendPayload(64'hBAD0 + 64'(i), w);
            check("drain_wait", 64'(w), 64'(0));
        end
        @(negedge clk);
        check("drain_idle", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        dirVal = '1;

        // Address wrap.
        sendHeader(0, 'hFFE, 4, w);
        for (int i = 0; i < 4; i++) sendPayload(64'hC0 + 64'(i), w);
        repeat (3) @(posedge clk);
        #1;

        // Zero-length transfer, then the very next header.
        sendHeader(1, 'h020, 0, w);
        @(negedge clk);
        check("len0_done", 64'(done), 64'(1));
        check("len0_rdy", 64'(inRdy), 64'(0));
        @(posedge clk);
        #1;
        sendHeader(3, 'h040, 2, w);
        check("len0_next_wait", 64'(w), 64'(0));
        sendPayload(64'hE0, w);
        sendPayload(64'hE1, w);
        repeat (3) @(posedge clk);
        #1;

        // Reset in the middle of a 6-word transfer.
        sendHeader(0, 'h200, 6, w);
        sendPayload(64'hF0, w);
        sendPayload(64'hF1, w);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        mLegal = 0;
        #1;
        checkResetOutputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        sendHeader(4, 'h300, 3, w);
        for (int i = 0; i < 3; i++) sendPayload(64'h90 + 64'(i), w);
        repeat (3) @(posedge clk);
        #1;

        // Randomised transfers with random Val and stream gaps.
        randMode = 1'b1;
        for (int t = 0; t < 40; t++) begin
            int ch, base, len;
            ch = $urandom_range(0, 6);
            base = $urandom_range(0, 4095);
            len = $urandom_range(0, 8);
            sendHeader(ch, base, len, w);
            gap();
            for (int i = 0; i < len; i++) begin
                d = {$urandom, $urandom};
                sendPayload(d, w);
                gap();
            end
        end
        randMode = 1'b0;

        repeat (5) @(negedge clk);
        check("wq_empty", 64'(wq.size()), 64'(0));
        check("doneq_empty", 64'(doneQ.size()), 64'(0));
        check("errq_empty", 64'(errQ.size()), 64'(0));
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
